// File: rtl/ternary_ram_pkg.sv
// Shared definitions for the ternary RAM: trit codes, controller states
// and the depth derivation used to size the storage array.
package ternary_ram_pkg;

   localparam logic [1:0] TRIT_0       = 2'b00;
   localparam logic [1:0] TRIT_1       = 2'b01;
   localparam logic [1:0] TRIT_2       = 2'b10;
   localparam logic [1:0] TRIT_ILLEGAL = 2'b11;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   // Number of locations addressable by a given count of trits (3**trits).
   function automatic int tern_depth(input int trits);
      int d;
      d = 32'sd1;
      for (int i = 0; i < trits; i++) begin
         d = d * 32'sd3;
      end
      return d;
   endfunction

endpackage

// File: rtl/tern_addr_decode.sv
// Combinational ternary-to-binary address conversion.
// A trit coded 11 is weighted as 2 and also raises the illegal flag, so the
// index never leaves the 0..3**ADDR_TRITS-1 range whatever the input.
module tern_addr_decode
   import ternary_ram_pkg::*;
#(
   parameter int ADDR_TRITS = 3,
   parameter int IDX_W      = 5
) (
   input  logic [2*ADDR_TRITS-1:0] addr,
   output logic [IDX_W-1:0]        index,
   output logic                    illegal
);

   int unsigned acc_s;
   int unsigned weight_s;
   logic [1:0]  trit_s;

   // Accumulate trit_i * 3**i and flag any 11 code.
   always_comb begin
      acc_s    = 32'd0;
      weight_s = 32'd1;
      trit_s   = 2'b00;
      illegal  = 1'b0;
      for (int i = 0; i < ADDR_TRITS; i++) begin
         trit_s = addr[2*i +: 2];
         case (trit_s)
            TRIT_0:       acc_s = acc_s;
            TRIT_1:       acc_s = acc_s + weight_s;
            TRIT_2:       acc_s = acc_s + (32'd2 * weight_s);
            TRIT_ILLEGAL: begin
               acc_s   = acc_s + (32'd2 * weight_s);
               illegal = 1'b1;
            end
            default:      acc_s = acc_s;
         endcase
         weight_s = weight_s * 32'd3;
      end
      index = IDX_W'(acc_s);
   end

endmodule

// File: rtl/ternary_ram.sv
// Ternary-word RAM with per-trit write mask and a self-clearing start-up.
// After reset the controller walks every location writing zero (busy high,
// no requests accepted), then serves one read or write per cycle.
// Optional build macro TERN_CHECK_EN: reject requests carrying an 11 trit in
// the address (or in masked-in write data) with an rsp_err pulse; when it is
// undefined, 11 is treated as 2 in addresses and stored verbatim in data.
module ternary_ram
   import ternary_ram_pkg::*;
#(
   parameter int WORD_TRITS = 9,
   parameter int ADDR_TRITS = 3
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [2*ADDR_TRITS-1:0] req_addr,
   input  logic [2*WORD_TRITS-1:0] req_wdata,
   input  logic [WORD_TRITS-1:0]   req_wmask,
   output logic                    rsp_valid,
   output logic [2*WORD_TRITS-1:0] rsp_data,
   output logic                    rsp_err,
   output logic                    busy
);

   localparam int DEPTH = tern_depth(ADDR_TRITS);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int DW    = 2 * WORD_TRITS;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 32'sd1);
`ifdef TERN_CHECK_EN
   localparam logic CHECK_EN = 1'b1;
`else
   localparam logic CHECK_EN = 1'b0;
`endif

   state_t            state_r;
   logic [IDX_W-1:0]  clr_cnt_r;
   logic [DW-1:0]     mem_r [DEPTH];
   logic              ready_r;
   logic              busy_r;
   logic              rsp_valid_r;
   logic              rsp_err_r;
   logic [DW-1:0]     rsp_data_r;

   logic [IDX_W-1:0]  index_s;
   logic              addr_illegal_s;
   logic              data_illegal_s;
   logic              accept_s;
   logic              err_s;
   logic              wr_en_s;
   logic              rd_en_s;
   logic [DW-1:0]     rd_word_s;
   logic [DW-1:0]     merged_s;

   tern_addr_decode #(
      .ADDR_TRITS (ADDR_TRITS),
      .IDX_W      (IDX_W)
   ) u_addr_decode (
      .addr    (req_addr),
      .index   (index_s),
      .illegal (addr_illegal_s)
   );

   // Request qualification, error detection and masked write-word merge.
   always_comb begin
      accept_s       = req_valid & ready_r;
      rd_word_s      = mem_r[index_s];
      data_illegal_s = 1'b0;
      merged_s       = rd_word_s;
      for (int k = 0; k < WORD_TRITS; k++) begin
         if (req_wmask[k]) begin
            merged_s[2*k +: 2] = req_wdata[2*k +: 2];
            if (req_wdata[2*k +: 2] == TRIT_ILLEGAL) begin
               data_illegal_s = 1'b1;
            end else begin
               data_illegal_s = data_illegal_s;
            end
         end else begin
            merged_s[2*k +: 2] = rd_word_s[2*k +: 2];
         end
      end
      err_s   = CHECK_EN & accept_s & ~reset
                & (addr_illegal_s | (req_write & data_illegal_s));
      wr_en_s = accept_s & req_write & ~err_s & ~reset;
      rd_en_s = accept_s & ~req_write & ~err_s & ~reset;
   end

   // Storage: cleared one location per cycle in CLEAR, else masked writes.
   always_ff @(posedge clock) begin
      if (state_r == ST_CLEAR) begin
         mem_r[clr_cnt_r] <= '0;
      end else if (wr_en_s) begin
         mem_r[index_s] <= merged_s;
      end
   end

   // Controller state, clear counter and registered response outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r     <= ST_CLEAR;
         clr_cnt_r   <= '0;
         ready_r     <= 1'b0;
         busy_r      <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_data_r  <= '0;
      end else begin
         case (state_r)
            ST_CLEAR: begin
               if (clr_cnt_r == LAST_IDX) begin
                  state_r   <= ST_IDLE;
                  clr_cnt_r <= '0;
                  ready_r   <= 1'b1;
                  busy_r    <= 1'b0;
               end else begin
                  clr_cnt_r <= clr_cnt_r + IDX_W'(1);
                  ready_r   <= 1'b0;
                  busy_r    <= 1'b1;
               end
            end
            ST_IDLE: begin
               ready_r <= 1'b1;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r   <= ST_CLEAR;
               clr_cnt_r <= '0;
               ready_r   <= 1'b0;
               busy_r    <= 1'b1;
            end
         endcase
         rsp_valid_r <= rd_en_s | err_s;
         rsp_err_r   <= err_s;
         if (err_s) begin
            rsp_data_r <= '0;
         end else if (rd_en_s) begin
            rsp_data_r <= rd_word_s;
         end
      end
   end

   assign req_ready = ready_r;
   assign busy      = busy_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_err   = rsp_err_r;
   assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_ternary_ram.sv
// Self-checking bench for ternary_ram: directed scenarios plus randomized
// traffic against a trit-level memory model (memory as an array of trit values).
module tb_ternary_ram;

   localparam int WT    = 9;
   localparam int AT    = 3;
   localparam int DW    = 2 * WT;
   localparam int AW    = 2 * AT;
   localparam int DEPTH = 27;
`ifdef TERN_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [WT-1:0] req_wmask;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic          busy;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            model [DEPTH][WT];
   bit            model_ready = 1'b0;
   logic [DW-1:0] last_d = '0;

   always #5 clock = ~clock;

   ternary_ram #(.WORD_TRITS(WT), .ADDR_TRITS(AT)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wmask (req_wmask),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic int addr_index(input logic [AW-1:0] a);
      int idx, w, t;
      idx = 0; w = 1;
      for (int i = 0; i < AT; i++) begin
         t = int'(a[2*i +: 2]);
         if (t == 3) t = 2;
         idx = idx + t * w;
         w = w * 3;
      end
      return idx;
   endfunction

   function automatic logic [AW-1:0] enc_addr(input int idx);
      logic [AW-1:0] a;
      int v;
      v = idx;
      for (int i = 0; i < AT; i++) begin
         a[2*i +: 2] = 2'(v % 3);
         v = v / 3;
      end
      return a;
   endfunction

   function automatic bit addr_bad(input logic [AW-1:0] a);
      bit b = 1'b0;
      for (int i = 0; i < AT; i++) if (a[2*i +: 2] == 2'b11) b = 1'b1;
      return b;
   endfunction

   function automatic bit data_bad(input logic [DW-1:0] d, input logic [WT-1:0] m);
      bit b = 1'b0;
      for (int k = 0; k < WT; k++) if (m[k] && d[2*k +: 2] == 2'b11) b = 1'b1;
      return b;
   endfunction

   function automatic logic [DW-1:0] pack(input int idx);
      logic [DW-1:0] r;
      int t;
      for (int k = 0; k < WT; k++) begin
         t = model[idx][k];
         r[2*k +: 2] = 2'(t);
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] r;
      for (int k = 0; k < WT; k++) begin
         if ($urandom_range(0, 9) == 0) r[2*k +: 2] = 2'b11;
         else r[2*k +: 2] = 2'($urandom_range(0, 2));
      end
      return r;
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      logic [AW-1:0] a;
      for (int i = 0; i < AT; i++) begin
         if ($urandom_range(0, 7) == 0) a[2*i +: 2] = 2'b11;
         else a[2*i +: 2] = 2'($urandom_range(0, 2));
      end
      return a;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++)
         for (int k = 0; k < WT; k++) model[i][k] = 0;
      last_d = '0;
   endtask

   // One clock of traffic: drive, predict from the model, check after the edge.
   task automatic cycle(input bit v, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [WT-1:0] m);
      bit            exp_v, exp_e, acc;
      logic [DW-1:0] exp_d;
      int            idx;
      req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
      n_checks++;
      if (req_ready !== model_ready) begin
         n_fail++;
         $display("FAIL ready: got %b expected %b", req_ready, model_ready);
      end
      acc = v && model_ready && !reset;
      exp_v = 1'b0; exp_e = 1'b0; exp_d = last_d;
      idx = addr_index(a);
      if (reset) begin
         exp_d = '0;
      end else if (acc) begin
         if (CHECK_EN && (addr_bad(a) || (w && data_bad(d, m)))) begin
            exp_v = 1'b1; exp_e = 1'b1; exp_d = '0;
         end else if (w) begin
            for (int k = 0; k < WT; k++) if (m[k]) model[idx][k] = int'(d[2*k +: 2]);
         end else begin
            exp_v = 1'b1; exp_d = pack(idx);
         end
      end
      step();
      if (reset) model_ready = 1'b0;
      n_checks++;
      if (rsp_valid !== exp_v) begin
         n_fail++;
         $display("FAIL rsp_valid: got %b expected %b (addr %b write %b)", rsp_valid, exp_v, a, w);
      end
      if (exp_v) begin
         n_checks++;
         if (rsp_err !== exp_e) begin
            n_fail++;
            $display("FAIL rsp_err: got %b expected %b", rsp_err, exp_e);
         end
      end
      n_checks++;
      if (rsp_data !== exp_d) begin
         n_fail++;
         $display("FAIL rsp_data: got %h expected %h (valid %b)", rsp_data, exp_d, exp_v);
      end
      last_d = exp_d;
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, '0, '0, '0);
   endtask

   // Count cycles with busy high after a reset edge; expects exactly DEPTH.
   task automatic wait_clear();
      int n = 0;
      model_ready = 1'b0;
      while (busy === 1'b1 && n < 100) begin
         n_checks++;
         if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== '0) begin
            n_fail++;
            $display("FAIL clear_outputs: ready %b rsp_valid %b rsp_data %h expected 0 0 0",
                     req_ready, rsp_valid, rsp_data);
         end
         n++;
         step();
      end
      n_checks++;
      if (n != DEPTH) begin
         n_fail++;
         $display("FAIL clear_length: busy cycles %0d expected %0d", n, DEPTH);
      end
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_clear: got %b expected 1", req_ready);
      end
      model_ready = 1'b1;
      clear_model();
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = '0;
      req_wdata = '0; req_wmask = '0;
      step();
      n_checks++;
      if (req_ready !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0 ||
          rsp_err !== 1'b0 || rsp_data !== '0) begin
         n_fail++;
         $display("FAIL reset_values: ready %b busy %b valid %b err %b data %h expected 0 1 0 0 0",
                  req_ready, busy, rsp_valid, rsp_err, rsp_data);
      end
      reset = 1'b0;
      wait_clear();
      req_valid = 1'b0;
   endtask

   task automatic test_clear_reads();
      cycle(1'b1, 1'b0, enc_addr(0), '0, '0);
      cycle(1'b1, 1'b0, enc_addr(13), '0, '0);
      cycle(1'b1, 1'b0, enc_addr(26), '0, '0);
      idle();
   endtask

   task automatic test_write_read_222();
      logic [DW-1:0] ones = {9{2'b01}};
      cycle(1'b1, 1'b1, 6'b101010, ones, 9'h1FF);
      cycle(1'b1, 1'b0, 6'b101010, '0, '0);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 18'h15555) begin
         n_fail++;
         $display("FAIL write_read_222: valid %b err %b data %h expected 1 0 15555",
                  rsp_valid, rsp_err, rsp_data);
      end
      idle();
   endtask

   task automatic test_mask();
      logic [DW-1:0] exp = {{6{2'b10}}, 2'b01, 2'b10, 2'b01};
      cycle(1'b1, 1'b1, enc_addr(5), {9{2'b10}}, 9'h1FF);
      cycle(1'b1, 1'b1, enc_addr(5), {9{2'b01}}, 9'b000000101);
      cycle(1'b1, 1'b0, enc_addr(5), '0, '0);
      n_checks++;
      if (rsp_data !== exp) begin
         n_fail++;
         $display("FAIL mask_merge: got %h expected %h", rsp_data, exp);
      end
      cycle(1'b1, 1'b1, enc_addr(5), {9{2'b00}}, 9'h000);
      cycle(1'b1, 1'b0, enc_addr(5), '0, '0);
      idle();
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] w;
      for (int i = 0; i < 5; i++) begin
         w = rand_word();
         w[1:0] = 2'((i + 1) % 3);
         w[3:2] = 2'((i + 1) / 3);
         cycle(1'b1, 1'b1, enc_addr(i), w, 9'h1FF);
      end
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, enc_addr(i), '0, '0);
      idle();
   endtask

   task automatic test_read_after_write();
      logic [AW-1:0] a;
      for (int j = 0; j < 8; j++) begin
         a = enc_addr($urandom_range(0, DEPTH - 1));
         cycle(1'b1, 1'b1, a, rand_word(), 9'($urandom));
         cycle(1'b1, 1'b0, a, '0, '0);
      end
      idle();
   endtask

   task automatic test_random();
      for (int j = 0; j < 400; j++)
         cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(),
               rand_word(), 9'($urandom));
      idle();
   endtask

   task automatic test_reset_inflight();
      reset = 1'b1;
      cycle(1'b1, 1'b0, enc_addr(3), '0, '0);
      reset = 1'b0;
      req_valid = 1'b0;
      wait_clear();
      cycle(1'b1, 1'b0, enc_addr(3), '0, '0);
      idle();
   endtask

   task automatic test_reset_midclear();
      req_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      wait_clear();
      test_clear_reads();
   endtask

   task automatic test_check();
      cycle(1'b1, 1'b1, enc_addr(4), {9{2'b01}}, 9'h1FF);
      cycle(1'b1, 1'b0, 6'b000011, '0, '0);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0) begin
         n_fail++;
         $display("FAIL check_addr: valid %b err %b data %h expected 1 1 0",
                  rsp_valid, rsp_err, rsp_data);
      end
      cycle(1'b1, 1'b1, enc_addr(4), {{8{2'b10}}, 2'b11}, 9'h1FF);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
         n_fail++;
         $display("FAIL check_data: valid %b err %b expected 1 1", rsp_valid, rsp_err);
      end
      cycle(1'b1, 1'b0, enc_addr(4), '0, '0);
      n_checks++;
      if (rsp_data !== {9{2'b01}}) begin
         n_fail++;
         $display("FAIL check_unchanged: got %h expected %h", rsp_data, {9{2'b01}});
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_clear_reads();
      test_write_read_222();
      test_mask();
      test_back_to_back();
      test_read_after_write();
`ifdef TERN_CHECK_EN
      test_check();
`endif
      test_random();
      test_reset_inflight();
      test_reset_midclear();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
